clock_gen: RTL and testbench
============================

Name: clock_gen

Overview:
- Programmable clock generator/divider. It derives a slow, glitch-free clock from the system reference clock `c`.
- Drives clocked datapath blocks (e.g. the ALU) and provides single-cycle edge strobes for logic kept in the `c` domain.
- Stop/start control and ratio changes occur only at half-period boundaries.

Parameters:
- DIV_W, 8, width of the divide-ratio input and internal half-period counter.
- DEFAULT_DIV, 1, half-period length (in `c` cycles) loaded at reset; must be 1..2^DIV_W-1.

Ports:
- c, input, 1, reference clock; all logic is posedge `c`.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, run enable for the generated clock.
- div_ratio, input, DIV_W, requested half-period length N in `c` cycles; 0 means stop.
- clk_out, output, 1, generated clock, registered (no combinational path to the output).
- rise_stb, output, 1, one-`c`-cycle pulse in the cycle where clk_out goes 0->1.
- fall_stb, output, 1, one-`c`-cycle pulse in the cycle where clk_out goes 1->0.
- running, output, 1, high while clk_out is toggling.

Behaviour:
- Clock and reset: one clock `c`; reset `rst_n` is asynchronous, active-low. Asserting rst_n low immediately forces:
  - clk_out=0, rise_stb=0, fall_stb=0, running=0
  - cnt=0, active_div=DEFAULT_DIV
- Reset mid-period truncates the current phase; no recovery of the partial count.
- Internal state: cnt (DIV_W bits) and active_div (DIV_W bits). active_div is the latched ratio for the current half-period.
- Normal operation (en=1, active_div!=0), each posedge c:
  - If cnt==active_div-1: toggle clk_out, set cnt=0, load active_div<=div_ratio.
  - Otherwise: cnt<=cnt+1.
- Result: clk_out period = 2*N `c` cycles, 50% duty. N=1 gives c/2.
- Ratio change: div_ratio is sampled only at a toggle. A change mid-half-period never shortens or stretches the current phase.
- After reset with en=1, the first toggle (0->1) occurs at posedge DEFAULT_DIV after rst_n release.
- Strobes:
  - rise_stb=1 for exactly the cycle in which clk_out registers 1 after being 0.
  - fall_stb likewise for 1->0.
  - Both are registered and never high simultaneously.
- Stop (en=0, or latched/sampled N=0):
  - If clk_out=1: continue counting until the normal falling toggle, then hold clk_out=0. fall_stb fires on that toggle.
  - If clk_out=0: hold immediately with cnt=0.
  - While stopped: cnt=0, running=0, active_div tracks div_ratio every cycle.
- Restart (en=1 and div_ratio!=0 while stopped): counting resumes from cnt=0. First rise occurs N cycles after the first enabled cycle.
- Simultaneous en fall and terminal count with clk_out=1: the toggle to 0 happens (fall_stb=1), then the block stops.
- running: 1 from the cycle of the first rise after start until clk_out has returned low in stop.
- Counter arithmetic is unsigned DIV_W bits. Maximum N=2^DIV_W-1; no wrap occurs because cnt is reset at terminal.

Optional Feature:
- Macro CLOCK_GEN_RISE_CNT_EN.
- When defined:
  - Adds output rise_cnt [31:0]: count of clk_out rising edges since reset.
  - Increments in the same cycle rise_stb=1, wraps 0xFFFFFFFF->0, resets to 0 on rst_n.
- When undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 with en=1, div_ratio=4 -> clk_out=0, strobes=0, running=0. Assert rst_n low mid-high-phase -> clk_out drops to 0 asynchronously.
- Divide-by-2: DEFAULT_DIV=1, div_ratio=1, en=1 -> clk_out toggles every posedge c (period 2). rise_stb and fall_stb alternate every cycle.
- Divide-by-8: div_ratio=4 -> clk_out high 4 cycles, low 4 cycles. rise_stb exactly once per 8 cycles.
- Ratio change mid-phase: div_ratio=4, switch to 2 at cnt=1 of a high phase -> that high phase still lasts 4 cycles; subsequent phases last 2.
- Glitch-free stop/restart: deassert en 1 cycle into a 4-cycle high phase -> high lasts the full 4 cycles, then fall_stb, clk_out held 0, running=0. Reassert en -> first rise 4 cycles later.
- Zero ratio, plus CLOCK_GEN_RISE_CNT_EN defined: div_ratio=0 -> clock stops low. With div_ratio=1 for 10 rises -> rise_cnt=10. Reset -> rise_cnt=0.

Source files
------------

// File: rtl/clock_gen.sv
// Programmable glitch-free clock divider: clk_out half-period = div_ratio cycles of c.
// Define CLOCK_GEN_RISE_CNT_EN to add a 32-bit counter of clk_out rising edges.
module clock_gen #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 1
) (
    input  logic             c,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_ratio,
    output logic             clk_out,
    output logic             rise_stb,
    output logic             fall_stb,
`ifdef CLOCK_GEN_RISE_CNT_EN
    output logic [31:0]      rise_cnt,
`endif
    output logic             running
);

    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] active_div_q, active_div_d;
    logic             clk_q, clk_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             run_q, run_d;
    logic             term;
    logic             stop_req;

    always_comb begin
        // A high phase that latched a zero ratio ends on the next edge rather than wrapping.
        term     = (active_div_q == '0) || (cnt_q == active_div_q - DIV_W'(1));
        stop_req = !en || (active_div_q == '0);

        cnt_d        = cnt_q;
        active_div_d = active_div_q;
        clk_d        = clk_q;
        rise_d       = 1'b0;
        fall_d       = 1'b0;
        run_d        = run_q;

        if (!clk_q && stop_req) begin
            // Parked low: hold at phase start, follow the requested ratio.
            cnt_d        = '0;
            active_div_d = div_ratio;
            run_d        = 1'b0;
        end else if (term) begin
            cnt_d        = '0;
            active_div_d = div_ratio;
            clk_d        = !clk_q;
            rise_d       = !clk_q;
            fall_d       = clk_q;
            run_d        = !clk_q ? 1'b1 : (en && (div_ratio != '0));
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            active_div_q <= DEF_DIV;
            clk_q        <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            active_div_q <= active_div_d;
            clk_q        <= clk_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            run_q        <= run_d;
        end
    end

    assign clk_out  = clk_q;
    assign rise_stb = rise_q;
    assign fall_stb = fall_q;
    assign running  = run_q;

`ifdef CLOCK_GEN_RISE_CNT_EN
    logic [31:0] rise_cnt_q, rise_cnt_d;

    always_comb begin
        rise_cnt_d = rise_cnt_q;
        if (rise_d) rise_cnt_d = rise_cnt_q + 32'd1;
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) rise_cnt_q <= '0;
        else        rise_cnt_q <= rise_cnt_d;
    end

    assign rise_cnt = rise_cnt_q;
`endif

endmodule

// File: tb/tb_clock_gen.sv
// Directed vector bench for clock_gen: table-driven cycle checks plus multi-cycle corner sequences.
module tb_clock_gen;

    logic       c = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] div_ratio = 8'd0;
    logic       clk_out, rise_stb, fall_stb, running;
`ifdef CLOCK_GEN_RISE_CNT_EN
    logic [31:0] rise_cnt;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    clock_gen #(.DIV_W(8), .DEFAULT_DIV(1)) dut (
        .c        (c),
        .rst_n    (rst_n),
        .en       (en),
        .div_ratio(div_ratio),
        .clk_out  (clk_out),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb),
`ifdef CLOCK_GEN_RISE_CNT_EN
        .rise_cnt (rise_cnt),
`endif
        .running  (running)
    );

    always #5 c = ~c;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [7:0] div;
        logic       clk;
        logic       rise;
        logic       fall;
        logic       run;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic e, input logic [7:0] d,
                       input logic ck, input logic ri, input logic fa, input logic ru,
                       input int reps);
        vec_t v;
        v = '{r, e, d, ck, ri, fa, ru};
        for (int k = 0; k < reps; k++) vq.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge c);
        #1;
    endtask

    initial begin
        int r, h, n;

        // rst  en div  clk rise fall run  reps
        add(0, 1, 4,   0, 0, 0, 0,  2);   // held in reset
        add(1, 1, 1,   1, 1, 0, 1,  1);   // divide-by-2 from DEFAULT_DIV
        add(1, 1, 1,   0, 0, 1, 1,  1);
        add(1, 1, 1,   1, 1, 0, 1,  1);
        add(1, 1, 1,   0, 0, 1, 1,  1);
        add(1, 1, 4,   1, 1, 0, 1,  1);   // ratio 4 latched at this rise
        add(1, 1, 4,   1, 0, 0, 1,  3);
        add(1, 1, 4,   0, 0, 1, 1,  1);
        add(1, 1, 4,   0, 0, 0, 1,  3);
        add(1, 1, 4,   1, 1, 0, 1,  1);
        add(1, 1, 4,   1, 0, 0, 1,  1);   // cnt=1 of high phase
        add(1, 1, 2,   1, 0, 0, 1,  2);   // switch to 2 mid-phase: phase keeps 4
        add(1, 1, 2,   0, 0, 1, 1,  1);
        add(1, 1, 2,   0, 0, 0, 1,  1);
        add(1, 1, 2,   1, 1, 0, 1,  1);
        add(1, 1, 2,   1, 0, 0, 1,  1);
        add(1, 1, 2,   0, 0, 1, 1,  1);
        add(1, 1, 2,   0, 0, 0, 1,  1);
        add(1, 1, 4,   1, 1, 0, 1,  1);   // ratio back to 4
        add(1, 1, 4,   1, 0, 0, 1,  1);
        add(1, 0, 4,   1, 0, 0, 1,  2);   // en drops mid high phase
        add(1, 0, 4,   0, 0, 1, 0,  1);   // full-length high, then stop
        add(1, 0, 4,   0, 0, 0, 0,  2);
        add(1, 1, 4,   0, 0, 0, 0,  3);   // restart: rise on 4th enabled edge
        add(1, 1, 4,   1, 1, 0, 1,  1);
        add(1, 1, 4,   1, 0, 0, 1,  1);
        add(1, 1, 0,   1, 0, 0, 1,  2);   // zero ratio requested
        add(1, 1, 0,   0, 0, 1, 0,  1);
        add(1, 1, 0,   0, 0, 0, 0,  2);   // stopped low
        add(1, 1, 1,   0, 0, 0, 0,  1);   // ratio tracked while stopped
        add(1, 1, 1,   1, 1, 0, 1,  1);
        add(1, 1, 1,   0, 0, 1, 1,  1);
        add(1, 1, 1,   1, 1, 0, 1,  1);

        foreach (vq[i]) begin
            rst_n     = vq[i].rst_n;
            en        = vq[i].en;
            div_ratio = vq[i].div;
            step();
            chk("clk_out",  i, 32'(clk_out),  32'(vq[i].clk));
            chk("rise_stb", i, 32'(rise_stb), 32'(vq[i].rise));
            chk("fall_stb", i, 32'(fall_stb), 32'(vq[i].fall));
            chk("running",  i, 32'(running),  32'(vq[i].run));
        end

        // Asynchronous reset in the middle of a high phase.
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_clk", 0, 32'(clk_out), 32'd0);
        chk("async_rst_run", 0, 32'(running), 32'd0);
        chk("async_rst_stb", 0, 32'({rise_stb, fall_stb}), 32'd0);
        en = 1'b1;
        div_ratio = 8'd4;
        #3 rst_n = 1'b1;
        step();
        chk("first_rise_after_rst", 0, 32'({clk_out, rise_stb}), 32'd3);

        // Divide-by-8: four rises and 16 high cycles in 32 cycles.
        r = 0; h = 0;
        for (int k = 0; k < 32; k++) begin
            step();
            if (rise_stb) r++;
            if (clk_out) h++;
        end
        chk("div8_rises", 0, 32'(r), 32'd4);
        chk("div8_high",  0, 32'(h), 32'd16);

        // Maximum ratio: a full 255-cycle high phase.
        div_ratio = 8'd255;
        n = 0;
        do begin step(); n++; end while (!rise_stb && n < 600);
        chk("max_ratio_rise_seen", 0, 32'(rise_stb), 32'd1);
        n = 0;
        do begin step(); n++; end while (!fall_stb && n < 600);
        chk("max_ratio_high_len", 0, 32'(n), 32'd255);

`ifdef CLOCK_GEN_RISE_CNT_EN
        rst_n = 1'b0;
        div_ratio = 8'd1;
        #3 rst_n = 1'b1;
        for (int k = 0; k < 20; k++) step();
        chk("rise_cnt_10", 0, rise_cnt, 32'd10);
        #2 rst_n = 1'b0;
        #1;
        chk("rise_cnt_rst", 0, rise_cnt, 32'd0);
        rst_n = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
